// File: rtl/classify_stage.sv
// Decode-stage instruction classifier: combinational MIPS-subset decode feeding a
// 2-entry elastic buffer (main + skid) with flush, plus saturating per-class counters.
module classify_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [1:0]           out_class,
  output logic                 out_is_branch,
  output logic                 out_is_load,
  output logic                 out_is_store,
  output logic                 out_is_jump,
  output logic                 out_is_trap,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] cnt_r,
  output logic [CNT_WIDTH-1:0] cnt_i,
  output logic [CNT_WIDTH-1:0] cnt_j,
  output logic [CNT_WIDTH-1:0] cnt_illegal
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [1:0] C_R   = 2'b00;
  localparam logic [1:0] C_I   = 2'b01;
  localparam logic [1:0] C_J   = 2'b10;
  localparam logic [1:0] C_ILL = 2'b11;

  // Entry layout: {instr, pc, class[1:0], branch, load, store, jump, trap}
  localparam int EW = 32 + PC_WIDTH + 7;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [6:0]    dec;
  logic [EW-1:0] in_ent;
  logic          accept, fire;

  function automatic logic [6:0] decode(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [5:0] fn);
    logic [1:0] cls;
    logic br, ld, st, jp, tr;
    cls = C_ILL;
    br = 1'b0; ld = 1'b0; st = 1'b0; jp = 1'b0; tr = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h03, 6'h10, 6'h12, 6'h1A, 6'h21, 6'h23: cls = C_R;
          6'h08:        begin cls = C_R; jp = 1'b1; end
          6'h0C, 6'h0D: begin cls = C_R; tr = 1'b1; end
          default: ;
        endcase
      end
      6'h01: if (rt == 5'h00 || rt == 5'h01) begin cls = C_I; br = 1'b1; end
      6'h04, 6'h05:        begin cls = C_I; br = 1'b1; end
      6'h09, 6'h0D, 6'h0F: cls = C_I;
      6'h23:               begin cls = C_I; ld = 1'b1; end
      6'h28, 6'h2B:        begin cls = C_I; st = 1'b1; end
      6'h02, 6'h03:        begin cls = C_J; jp = 1'b1; end
      default: ;
    endcase
    return {cls, br, ld, st, jp, tr};
  endfunction

  assign dec    = decode(in_instr[31:26], in_instr[20:16], in_instr[5:0]);
  assign in_ent = {in_instr, in_pc, dec};

  // Both handshake outputs derive from the registered state only.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin main_d = in_ent; state_d = ONE; end
        ONE: begin
          case ({accept, fire})
            2'b10:   begin skid_d = in_ent; state_d = TWO; end
            2'b11:   main_d = in_ent;
            2'b01:   state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: if (fire) begin main_d = skid_q; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clear)
        cnt_d[k] = '0;
      else if (fire && !flush && out_class == 2'(k) && cnt_q[k] != '1)
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {out_instr, out_pc, out_class, out_is_branch, out_is_load,
          out_is_store, out_is_jump, out_is_trap} = main_q;

  assign cnt_r       = cnt_q[0];
  assign cnt_i       = cnt_q[1];
  assign cnt_j       = cnt_q[2];
  assign cnt_illegal = cnt_q[3];

endmodule

// File: tb/tb_classify_stage.sv
// Scoreboard bench for classify_stage: a wide-counter and a 2-bit-counter instance share
// stimulus; the driver queues expected entries, a negedge monitor retires and checks them.
module tb_classify_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready, cnt_clear;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, br, ld, st, jp, tr;
  logic [31:0] out_instr, out_pc;
  logic [1:0]  out_class;
  logic [15:0] cr, ci, cj, cx;

  logic        in_ready2, out_valid2, br2, ld2, st2, jp2, tr2;
  logic [31:0] out_instr2, out_pc2;
  logic [1:0]  out_class2;
  logic [1:0]  cr2, ci2, cj2, cx2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  cls;
    logic [4:0]  fl;   // {branch, load, store, jump, trap}
  } exp_t;

  exp_t sb[$];
  int   mc[4];
  int   mc2[4];

  always #5 clk = ~clk;

  classify_stage #(.PC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_class(out_class), .out_is_branch(br),
    .out_is_load(ld), .out_is_store(st), .out_is_jump(jp), .out_is_trap(tr),
    .cnt_clear(cnt_clear), .cnt_r(cr), .cnt_i(ci), .cnt_j(cj), .cnt_illegal(cx)
  );

  classify_stage #(.PC_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_pc(out_pc2), .out_class(out_class2), .out_is_branch(br2),
    .out_is_load(ld2), .out_is_store(st2), .out_is_jump(jp2), .out_is_trap(tr2),
    .cnt_clear(cnt_clear), .cnt_r(cr2), .cnt_i(ci2), .cnt_j(cj2), .cnt_illegal(cx2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference classification, written from the instruction-set tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rt;
    op = ins[31:26]; rt = ins[20:16]; fn = ins[5:0];
    e.instr = ins; e.pc = pc; e.cls = 2'b11; e.fl = 5'b0;
    if (op == 6'h00 && fn inside {6'h00, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h10,
                                  6'h12, 6'h1A, 6'h21, 6'h23}) begin
      e.cls = 2'b00;
      if (fn == 6'h08) e.fl = 5'b00010;
      if (fn inside {6'h0C, 6'h0D}) e.fl = 5'b00001;
    end else if (op == 6'h01 && rt inside {5'h00, 5'h01}) begin
      e.cls = 2'b01; e.fl = 5'b10000;
    end else if (op inside {6'h04, 6'h05, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h28, 6'h2B}) begin
      e.cls = 2'b01;
      if (op inside {6'h04, 6'h05}) e.fl = 5'b10000;
      if (op == 6'h23)              e.fl = 5'b01000;
      if (op inside {6'h28, 6'h2B}) e.fl = 5'b00100;
    end else if (op inside {6'h02, 6'h03}) begin
      e.cls = 2'b10; e.fl = 5'b00010;
    end
    return e;
  endfunction

  task automatic cmp_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [1:0] cls, input logic [4:0] fl);
    chk({tag, "_instr"}, ins, sb[0].instr);
    chk({tag, "_pc"},    pc,  sb[0].pc);
    chk({tag, "_class"}, cls, sb[0].cls);
    chk({tag, "_flags"}, fl,  sb[0].fl);
  endtask

  // Monitor: checks state against the scoreboard, then retires what the coming edge consumes.
  always @(negedge clk) begin
    chk("in_ready",   in_ready,   sb.size() < 2);
    chk("out_valid",  out_valid,  sb.size() > 0);
    chk("in_ready2",  in_ready2,  sb.size() < 2);
    chk("out_valid2", out_valid2, sb.size() > 0);
    chk("cnt_r", cr, mc[0]); chk("cnt_i", ci, mc[1]);
    chk("cnt_j", cj, mc[2]); chk("cnt_ill", cx, mc[3]);
    chk("cnt2_r", cr2, mc2[0]); chk("cnt2_i", ci2, mc2[1]);
    chk("cnt2_j", cj2, mc2[2]); chk("cnt2_ill", cx2, mc2[3]);
    if (sb.size() > 0) begin
      cmp_out("out",  out_instr,  out_pc,  out_class,  {br, ld, st, jp, tr});
      cmp_out("out2", out_instr2, out_pc2, out_class2, {br2, ld2, st2, jp2, tr2});
    end
    if (rst) begin
      sb.delete();
      for (int k = 0; k < 4; k++) begin mc[k] = 0; mc2[k] = 0; end
    end else begin
      int c;
      c = -1;
      if (flush) sb.delete();
      else if (sb.size() > 0 && out_ready) c = sb.pop_front().cls;
      for (int k = 0; k < 4; k++) begin
        if (cnt_clear) begin
          mc[k] = 0; mc2[k] = 0;
        end else if (c == k) begin
          if (mc[k] < 65535) mc[k]++;
          if (mc2[k] < 3)    mc2[k]++;
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic clr, input logic r);
    logic acc;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    flush = fl; cnt_clear = clr; rst = r;
    acc = iv && !fl && !r && (sb.size() < 2);
    @(negedge clk); #1;
    if (acc) sb.push_back(ref_decode(ins, pc));
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [31:0] ins, input logic ordy);
    step(1'b1, ins, $urandom, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_pc"},    out_pc, 32'h0);
    chk({tag, "_class"}, out_class, 2'b00);
    chk({tag, "_flags"}, {br, ld, st, jp, tr}, 5'b0);
    chk({tag, "_cnts"},  {cr, ci, cj, cx}, 64'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fl [10];
    logic [5:0]  ol [10];
    fl = '{6'h00, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h10, 6'h12, 6'h1A, 6'h21, 6'h23};
    ol = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h28, 6'h2B};
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin w[31:26] = 6'h00; w[5:0] = fl[$urandom_range(0, 9)]; end
      1: begin w[31:26] = 6'h00; end
      2: begin w[31:26] = 6'h01; if ($urandom_range(0, 1) == 1) w[20:16] = 5'($urandom_range(0, 1)); end
      3: w[31:26] = ol[$urandom_range(0, 9)];
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_reset_outputs("rst0");

    // Basic stream, one class each
    push1(32'h00851021, 1'b1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_class", out_class, 2'b00);
    push1(32'h8C880004, 1'b1);
    chk("lw_load", ld, 1'b1);
    push1(32'h08000010, 1'b1);
    chk("j_jump", jp, 1'b1);
    push1(32'hFC000000, 1'b1);
    chk("ill_class", out_class, 2'b11);
    idle(1'b1); idle(1'b1);
    chk("t1_cnts", {cr, ci, cj, cx}, {16'd1, 16'd1, 16'd1, 16'd1});

    // Backpressure into the skid entry, then release
    push1(32'h24420001, 1'b0);
    chk("t2_rdy1", in_ready, 1'b1);
    push1(32'hAC430008, 1'b0);
    chk("t2_rdy2", in_ready, 1'b0);
    chk("t2_hold", out_instr, 32'h24420001);
    idle(1'b1);
    chk("t2_second", out_instr, 32'hAC430008);
    chk("t2_rdy3", in_ready, 1'b1);
    idle(1'b1);
    chk("t2_empty", out_valid, 1'b0);

    // Decode corner cases
    push1(32'h0000000C, 1'b1);
    chk("sys_trap", {out_class, tr}, 3'b001);
    push1(32'h03E00008, 1'b1);
    chk("jr_jump", {out_class, jp}, 3'b001);
    push1(32'h04110000, 1'b1);
    chk("regimm_ill", {out_class, br}, 3'b110);
    push1(32'h0000003F, 1'b1);
    chk("funct_ill", out_class, 2'b11);
    idle(1'b1);

    // Flush while full, with input and fire both offered
    push1(32'h3C010001, 1'b0);
    push1(32'h34210002, 1'b0);
    step(1'b1, 32'h00000000, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ready", in_ready, 1'b1);
    idle(1'b1);

    // Saturation on the 2-bit instance; clear beats a simultaneous fire
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) push1(32'h00851021, 1'b1);
    idle(1'b1);
    chk("t5_sat2", cr2, 2'd3);
    chk("t5_wide", cr, 16'd5);
    push1(32'h00851021, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_clr2", cr2, 2'd0);
    chk("t5_clr", cr, 16'd0);

    // Reset while holding an entry
    push1(32'h8C880004, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_reset_outputs("rst1");
    idle(1'b1); idle(1'b1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0);
    end
    repeat (4) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
